// File: rtl/fdiv_issue_seq_pkg.sv
// Shared FPU definitions for the divide issue sequencer: operand class bit
// positions, the canonical quiet NaN and the sequencer state encoding.
package fdiv_issue_seq_pkg;

    localparam int CLASS_BIT_QNAN      = 5;
    localparam int CLASS_BIT_SNAN      = 4;
    localparam int CLASS_BIT_INF       = 3;
    localparam int CLASS_BIT_NORMAL    = 2;
    localparam int CLASS_BIT_SUBNORMAL = 1;
    localparam int CLASS_BIT_ZERO      = 0;

    localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;

    localparam int SIG_W  = 24;
    localparam int FRAC_W = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fdiv_state_e;

endpackage

// File: rtl/fdiv_issue_seq_fp_unpack.sv
// Combinational IEEE-754 single unpack into signed unbiased exponent, normalized
// significand (hidden bit at [23]) and one-hot class. The sign bit is not needed here.
module fdiv_issue_seq_fp_unpack
    import fdiv_issue_seq_pkg::*;
#(
    parameter int CLASS_W = 6,
    parameter int EXP_W   = 10
) (
    input  logic        [30:0]        magnitude,
    output logic signed [EXP_W-1:0]   exponent,
    output logic        [SIG_W-1:0]   significand,
    output logic        [CLASS_W-1:0] fp_class
);

    logic [7:0]        biased;
    logic [FRAC_W-1:0] frac;
    logic [4:0]        lz;

    // Leading zeros of a nonzero fraction; the highest set bit is the last one seen.
    function automatic logic [4:0] lead_zeros(input logic [FRAC_W-1:0] f);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < FRAC_W; i++) begin
            if (f[i]) n = 5'(FRAC_W - 1 - i);
        end
        return n;
    endfunction

    assign biased = magnitude[30:23];
    assign frac   = magnitude[22:0];
    assign lz     = lead_zeros(frac);

    always_comb begin
        exponent    = '0;
        significand = '0;
        fp_class    = '0;
        if (biased == 8'hFF) begin
            exponent    = EXP_W'(128);
            significand = {1'b1, frac};
            if (frac == '0)
                fp_class[CLASS_BIT_INF] = 1'b1;
            else if (frac[FRAC_W-1])
                fp_class[CLASS_BIT_QNAN] = 1'b1;
            else
                fp_class[CLASS_BIT_SNAN] = 1'b1;
        end else if (biased == 8'h00) begin
            if (frac == '0) begin
                fp_class[CLASS_BIT_ZERO] = 1'b1;
            end else begin
                // Shift the first set bit up into the hidden-bit position.
                fp_class[CLASS_BIT_SUBNORMAL] = 1'b1;
                significand = {1'b0, frac} << (lz + 5'd1);
                exponent    = EXP_W'(-127 - int'(lz));
            end
        end else begin
            fp_class[CLASS_BIT_NORMAL] = 1'b1;
            exponent    = EXP_W'(int'(biased) - 127);
            significand = {1'b1, frac};
        end
    end

endmodule

// File: rtl/fdiv_issue_seq.sv
// Initiator side of the FPU divider handshake: accepts a request, unpacks and holds
// operands, pulses the divider enable and returns the result. Optional FDIV_WATCHDOG_EN.
module fdiv_issue_seq
    import fdiv_issue_seq_pkg::*;
#(
    parameter int CLASS_W     = 6,
    parameter int EXP_W       = 10,
    parameter int TIMEOUT_CYC = 40
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      reqValid_i,
    output logic                      reqReady_o,
    input  logic        [31:0]        rs1_i,
    input  logic        [31:0]        rs2_i,
    input  logic        [2:0]         rm_i,
    output logic                      respValid_o,
    input  logic                      respReady_i,
    output logic        [31:0]        result_o,
    output logic                      timeout_o,
    output logic                      divEnable_o,
    output logic        [31:0]        divRs1_o,
    output logic        [31:0]        divRs2_o,
    output logic signed [EXP_W-1:0]   divRs1Exp_o,
    output logic signed [EXP_W-1:0]   divRs2Exp_o,
    output logic        [SIG_W-1:0]   divRs1Sig_o,
    output logic        [SIG_W-1:0]   divRs2Sig_o,
    output logic        [CLASS_W-1:0] divRs1Class_o,
    output logic        [CLASS_W-1:0] divRs2Class_o,
    output logic        [2:0]         divRm_o,
    input  logic                      divReady_i,
    input  logic        [31:0]        fdivOut_i
);

    fdiv_state_e state_q, state_d;
    logic        accept;
    logic        wd_fire;

    logic signed [EXP_W-1:0]   rs1_exp_c, rs2_exp_c;
    logic        [SIG_W-1:0]   rs1_sig_c, rs2_sig_c;
    logic        [CLASS_W-1:0] rs1_class_c, rs2_class_c;

    fdiv_issue_seq_fp_unpack #(.CLASS_W(CLASS_W), .EXP_W(EXP_W)) u_unpack_rs1 (
        .magnitude   (rs1_i[30:0]),
        .exponent    (rs1_exp_c),
        .significand (rs1_sig_c),
        .fp_class    (rs1_class_c)
    );

    fdiv_issue_seq_fp_unpack #(.CLASS_W(CLASS_W), .EXP_W(EXP_W)) u_unpack_rs2 (
        .magnitude   (rs2_i[30:0]),
        .exponent    (rs2_exp_c),
        .significand (rs2_sig_c),
        .fp_class    (rs2_class_c)
    );

    assign accept = (state_q == ST_IDLE) && reqValid_i;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        reqReady_o  = 1'b0;
        divEnable_o = 1'b0;
        respValid_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                reqReady_o = 1'b1;
                if (reqValid_i) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                divEnable_o = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (divReady_i || wd_fire) state_d = ST_RESP;
            end
            ST_RESP: begin
                respValid_o = 1'b1;
                if (respReady_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operands are only loaded on acceptance so they stay stable through WAIT and RESP.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            divRs1_o      <= '0;
            divRs2_o      <= '0;
            divRm_o       <= '0;
            divRs1Exp_o   <= '0;
            divRs2Exp_o   <= '0;
            divRs1Sig_o   <= '0;
            divRs2Sig_o   <= '0;
            divRs1Class_o <= '0;
            divRs2Class_o <= '0;
            result_o      <= '0;
        end else begin
            if (accept) begin
                divRs1_o      <= rs1_i;
                divRs2_o      <= rs2_i;
                divRm_o       <= rm_i;
                divRs1Exp_o   <= rs1_exp_c;
                divRs2Exp_o   <= rs2_exp_c;
                divRs1Sig_o   <= rs1_sig_c;
                divRs2Sig_o   <= rs2_sig_c;
                divRs1Class_o <= rs1_class_c;
                divRs2Class_o <= rs2_class_c;
            end
            if (state_q == ST_WAIT) begin
                if (divReady_i)
                    result_o <= fdivOut_i;
                else if (wd_fire)
                    result_o <= CANON_QNAN;
            end
        end
    end

`ifdef FDIV_WATCHDOG_EN
    logic [7:0] wd_cnt_q;
    logic       timeout_q;

    // Counter restarts with the ISSUE cycle at 0, so it reads N in the Nth cycle after ISSUE.
    assign wd_fire = (state_q == ST_WAIT) && !divReady_i &&
                     (wd_cnt_q == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                wd_cnt_q  <= '0;
                timeout_q <= 1'b0;
            end else if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
                wd_cnt_q <= wd_cnt_q + 8'd1;
            end
            if (wd_fire) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign wd_fire   = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_issue_seq.sv
// Scoreboard bench for fdiv_issue_seq with a behavioural divider and unpack model.
module tb_fdiv_issue_seq;

    logic              clk_i, reset_i;
    logic              reqValid_i, reqReady_o;
    logic [31:0]       rs1_i, rs2_i;
    logic [2:0]        rm_i;
    logic              respValid_o, respReady_i;
    logic [31:0]       result_o;
    logic              timeout_o, divEnable_o;
    logic [31:0]       divRs1_o, divRs2_o;
    logic signed [9:0] divRs1Exp_o, divRs2Exp_o;
    logic [23:0]       divRs1Sig_o, divRs2Sig_o;
    logic [5:0]        divRs1Class_o, divRs2Class_o;
    logic [2:0]        divRm_o;
    logic              divReady_i;
    logic [31:0]       fdivOut_i;

    fdiv_issue_seq dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .reqValid_i(reqValid_i), .reqReady_o(reqReady_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rm_i(rm_i),
        .respValid_o(respValid_o), .respReady_i(respReady_i),
        .result_o(result_o), .timeout_o(timeout_o),
        .divEnable_o(divEnable_o),
        .divRs1_o(divRs1_o), .divRs2_o(divRs2_o),
        .divRs1Exp_o(divRs1Exp_o), .divRs2Exp_o(divRs2Exp_o),
        .divRs1Sig_o(divRs1Sig_o), .divRs2Sig_o(divRs2Sig_o),
        .divRs1Class_o(divRs1Class_o), .divRs2Class_o(divRs2Class_o),
        .divRm_o(divRm_o),
        .divReady_i(divReady_i), .fdivOut_i(fdivOut_i)
    );

    typedef struct {
        logic [31:0] rs1, rs2;
        logic [2:0]  rm;
        int          e1, e2;
        logic [23:0] s1, s2;
        logic [5:0]  c1, c2;
    } op_t;

    op_t         op_q[$];
    logic [32:0] res_q[$];   // {timeout, result}

    int n_pass  = 0;
    int n_total = 0;
    bit bp_hold = 0;
    bit div_mute = 0;
    int spur_req = 0;
    int spur_ack = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, req);
    endtask

    // Value-level unpack: renormalize a subnormal by doubling until the hidden bit is set.
    function automatic void ref_unpack(input logic [31:0] x, output int e,
                                       output logic [23:0] s, output logic [5:0] c);
        int bexp, m;
        bexp = int'(x[30:23]);
        m    = int'(x[22:0]);
        if (bexp == 255) begin
            e = 128; s = {1'b1, x[22:0]};
            c = (m == 0) ? 6'b001000 : (x[22] ? 6'b100000 : 6'b010000);
        end else if (bexp == 0 && m == 0) begin
            e = 0; s = 24'h0; c = 6'b000001;
        end else if (bexp == 0) begin
            e = -126;
            while (m < 8388608) begin m = m * 2; e = e - 1; end
            s = 24'(m); c = 6'b000010;
        end else begin
            e = bexp - 127; s = 24'(m + 8388608); c = 6'b000100;
        end
    endfunction

    function automatic logic [31:0] inf_or_max(input logic sgn, input logic [2:0] rm);
        if (rm == 3'd1 || (rm == 3'd2 && !sgn) || (rm == 3'd3 && sgn))
            return {sgn, 31'h7F7FFFFF};
        return {sgn, 31'h7F800000};
    endfunction

    // Reference divider: IEEE special cases, otherwise real division truncated to 24 bits.
    function automatic logic [31:0] ref_fdiv(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] rm);
        int ea, eb, e;
        logic [23:0] sa, sb;
        logic [5:0] ca, cb;
        logic sgn;
        real q;
        ref_unpack(a, ea, sa, ca);
        ref_unpack(b, eb, sb, cb);
        sgn = a[31] ^ b[31];
        if (ca[5] || ca[4] || cb[5] || cb[4]) return 32'h7FC00000;
        if ((ca[3] && cb[3]) || (ca[0] && cb[0])) return 32'h7FC00000;
        if (ca[3] || cb[0]) return inf_or_max(sgn, rm);
        if (ca[0] || cb[3]) return {sgn, 31'h0};
        q = (real'(sa) / real'(sb)) * (2.0 ** (ea - eb));
        e = 0;
        while (q >= 2.0) begin q = q / 2.0; e++; end
        while (q < 1.0)  begin q = q * 2.0; e--; end
        if (e > 127)  return inf_or_max(sgn, rm);
        if (e < -126) return {sgn, 31'h0};
        return {sgn, 8'(e + 127), 23'($rtoi((q - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
            0: return {s, 31'h0};
            1: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
            2: return {s, 8'hFF, 23'h0};
            3: return {s, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            default: return {s, 8'($urandom_range(100, 154)), 23'($urandom_range(0, 32'h7FFFFF))};
        endcase
    endfunction

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Divider: detects the enable, waits a random latency, pulses ready on a falling edge.
    initial begin
        divReady_i = 1'b0;
        fdivOut_i  = 32'h0;
        forever begin
            @(negedge clk_i);
            if (divEnable_o && !div_mute) begin
                repeat ($urandom_range(1, 6)) @(negedge clk_i);
                divReady_i = 1'b1;
                fdivOut_i  = ref_fdiv(divRs1_o, divRs2_o, divRm_o);
                @(negedge clk_i);
                divReady_i = 1'b0;
            end else if (spur_req != spur_ack) begin
                divReady_i = 1'b1;
                fdivOut_i  = 32'hDEADBEEF;
                @(negedge clk_i);
                divReady_i = 1'b0;
                spur_ack++;
            end
        end
    end

    initial begin
        respReady_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #3;
            respReady_i = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops operand expectations on each enable and results on each handshake.
    initial begin
        op_t         o;
        logic [32:0] r;
        bit          en_prev = 0, held_vld = 0;
        logic [31:0] held1 = 0, held2 = 0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                en_prev = 0; held_vld = 0;
            end else begin
                if (en_prev) chk("enable_one_cycle", 32'(divEnable_o), 32'd0);
                if (divEnable_o) begin
                    if (op_q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
                    else begin
                        o = op_q.pop_front();
                        chk("div_rs1", divRs1_o, o.rs1);
                        chk("div_rs2", divRs2_o, o.rs2);
                        chk("div_rm", 32'(divRm_o), 32'(o.rm));
                        chk("rs1_exp", int'(divRs1Exp_o), o.e1);
                        chk("rs2_exp", int'(divRs2Exp_o), o.e2);
                        chk("rs1_sig", 32'(divRs1Sig_o), 32'(o.s1));
                        chk("rs2_sig", 32'(divRs2Sig_o), 32'(o.s2));
                        chk("rs1_class", 32'(divRs1Class_o), 32'(o.c1));
                        chk("rs2_class", 32'(divRs2Class_o), 32'(o.c2));
                    end
                end
                if (held_vld && !reqReady_o) begin
                    chk("operand_hold_rs1", divRs1_o, held1);
                    chk("operand_hold_rs2", divRs2_o, held2);
                end
                held_vld = !reqReady_o;
                held1 = divRs1_o;
                held2 = divRs2_o;
                en_prev = divEnable_o;
                if (respValid_o && respReady_i) begin
                    if (res_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
                    else begin
                        r = res_q.pop_front();
                        chk("result", result_o, r[31:0]);
                        chk("timeout_flag", 32'(timeout_o), 32'(r[32]));
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                         input bit want_resp);
        op_t o;
        bit  ok;
        ok = 0;
        @(posedge clk_i);
        #2;
        reqValid_i = 1'b1; rs1_i = a; rs2_i = b; rm_i = m;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk_i);
            if (reqReady_o) ok = 1;
        end
        if (ok) begin
            o.rs1 = a; o.rs2 = b; o.rm = m;
            ref_unpack(a, o.e1, o.s1, o.c1);
            ref_unpack(b, o.e2, o.s2, o.c2);
            op_q.push_back(o);
            if (want_resp) res_q.push_back({1'b0, ref_fdiv(a, b, m)});
        end else begin
            chk("accept_wait_expired", 32'd0, 32'd1);
        end
        @(posedge clk_i);
        #2;
        reqValid_i = 1'b0;
    endtask

    task automatic wait_issue();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (divEnable_o) seen = 1;
        end
        if (!seen) chk("issue_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_resp();
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (respValid_o) seen = 1;
        end
        if (!seen) chk("resp_wait_expired", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: actual expired required finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] held;
        reset_i = 1'b1; reqValid_i = 1'b0; rs1_i = '0; rs2_i = '0; rm_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_reqReady", 32'(reqReady_o), 32'd1);
        chk("rst_respValid", 32'(respValid_o), 32'd0);
        chk("rst_divEnable", 32'(divEnable_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_divRs1", divRs1_o, 32'd0);
        chk("rst_divRs1Class", 32'(divRs1Class_o), 32'd0);
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;

        // Basic divide 6.0 / 2.0
        issue(32'h40C00000, 32'h40000000, 3'd0, 1);
        wait_issue();
        chk("basic_rs1_exp", int'(divRs1Exp_o), 2);
        chk("basic_rs1_sig", 32'(divRs1Sig_o), 32'h00C00000);
        chk("basic_rs1_class", 32'(divRs1Class_o), 32'h04);
        chk("basic_rs2_exp", int'(divRs2Exp_o), 1);
        wait_resp();
        chk("basic_result", result_o, 32'h40400000);

        // Subnormal and negative zero unpack
        issue(32'h00000001, 32'h3F800000, 3'd0, 1);
        wait_issue();
        chk("subn_exp", int'(divRs1Exp_o), -149);
        chk("subn_sig", 32'(divRs1Sig_o), 32'h00800000);
        chk("subn_class", 32'(divRs1Class_o), 32'h02);
        issue(32'h00400000, 32'h3F800000, 3'd0, 1);
        wait_issue();
        chk("subn_top_exp", int'(divRs1Exp_o), -127);
        issue(32'h80000000, 32'h3F800000, 3'd0, 1);
        wait_issue();
        chk("zero_class", 32'(divRs1Class_o), 32'h01);
        chk("zero_exp", int'(divRs1Exp_o), 0);
        chk("zero_sig", 32'(divRs1Sig_o), 32'h0);

        // Divide by zero under two rounding modes
        issue(32'h3F800000, 32'h00000000, 3'd0, 1);
        wait_resp();
        chk("divzero_rne", result_o, 32'h7F800000);
        issue(32'h3F800000, 32'h00000000, 3'd1, 1);
        wait_resp();
        chk("divzero_rtz", result_o, 32'h7F7FFFFF);

        // Backpressure: response held, second request refused
        bp_hold = 1;
        issue(32'h40400000, 32'h3F800000, 3'd2, 1);
        wait_resp();
        held = result_o;
        chk("bp_result", held, 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #2;
            reqValid_i = 1'b1; rs1_i = $urandom; rs2_i = $urandom;
            @(negedge clk_i);
            chk("bp_respValid", 32'(respValid_o), 32'd1);
            chk("bp_result_stable", result_o, held);
            chk("bp_reqReady", 32'(reqReady_o), 32'd0);
        end
        @(posedge clk_i);
        #2;
        reqValid_i = 1'b0;
        bp_hold = 0;

        // Reset while waiting on a divider that never answers
        div_mute = 1;
        issue(32'h3F800000, 32'h40000000, 3'd0, 0);
        wait_issue();
        repeat (10) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        @(posedge clk_i);
        #2;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("wrst_reqReady", 32'(reqReady_o), 32'd1);
        chk("wrst_respValid", 32'(respValid_o), 32'd0);
        chk("wrst_result", result_o, 32'd0);
        div_mute = 0;
        spur_req++;
        for (int i = 0; i < 20 && spur_ack != spur_req; i++) @(negedge clk_i);
        chk("spurious_pulse_sent", spur_ack, spur_req);
        repeat (3) @(negedge clk_i);
        chk("spurious_respValid", 32'(respValid_o), 32'd0);
        chk("spurious_result", result_o, 32'd0);

`ifdef FDIV_WATCHDOG_EN
        div_mute = 1;
        bp_hold = 1;
        issue(32'h3F800000, 32'h40000000, 3'd0, 0);
        res_q.push_back({1'b1, 32'h7FC00000});
        wait_issue();
        repeat (39) @(negedge clk_i);
        chk("wd_before_limit", 32'(respValid_o), 32'd0);
        @(negedge clk_i);
        chk("wd_respValid", 32'(respValid_o), 32'd1);
        chk("wd_result", result_o, 32'h7FC00000);
        chk("wd_timeout", 32'(timeout_o), 32'd1);
        bp_hold = 0;
        div_mute = 0;
`endif

        // Randomized traffic across all operand classes and rounding modes
        for (int n = 0; n < 40; n++) begin
            issue(rand_op(), rand_op(), 3'($urandom_range(0, 4)), 1);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end

        for (int i = 0; i < 500 && (res_q.size() != 0 || op_q.size() != 0); i++)
            @(negedge clk_i);
        chk("scoreboard_drained", 32'(res_q.size() + op_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
